// File: rtl/add_seq_ctrl.sv
// Multi-nibble unsigned adder sequencer that time-shares one external 4-bit adder.
// The adder has no carry-in, so an incoming carry costs one extra increment pass.
module add_seq_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [4*NIBBLES-1:0] op_a,
   input  logic [4*NIBBLES-1:0] op_b,
   output logic                 busy,
   output logic                 done,
   output logic [4*NIBBLES:0]   sum,
   output logic [3:0]           add_a,
   output logic [3:0]           add_b,
   input  logic [4:0]           add_c
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {
      IDLE,
      ADD,
      INC,
      DONE
   } state_t;

   state_t         r_state;
   state_t         w_nextState;
   logic [W-1:0]   r_opA;
   logic [W-1:0]   r_opB;
   logic [IW-1:0]  r_idx;
   logic           r_cy;
   logic [4:0]     r_p;
   logic [W:0]     r_sum;

   logic [3:0]     w_nibA;
   logic [3:0]     w_nibB;
   logic           w_last;
   logic           w_write;
   logic           w_newCy;

   assign w_nibA = r_opA[{r_idx, 2'b00} +: 4];
   assign w_nibB = r_opB[{r_idx, 2'b00} +: 4];
   assign w_last = (r_idx == IW'(NIBBLES - 1));

   // A nibble is committed on a carry-free ADD pass or on the INC pass.
   assign w_write = ((r_state == ADD) && !r_cy) || (r_state == INC);
   assign w_newCy = (r_state == INC) ? (r_p[4] | add_c[4]) : add_c[4];

   assign sum = r_sum;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      add_a       = 4'd0;
      add_b       = 4'd0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_nextState = ADD;
            end
         end
         ADD: begin
            busy  = 1'b1;
            add_a = w_nibA;
            add_b = w_nibB;
            if (r_cy) begin
               w_nextState = INC;
            end else if (w_last) begin
               w_nextState = DONE;
            end
         end
         INC: begin
            busy  = 1'b1;
            add_a = r_p[3:0];
            add_b = 4'b0001;
            w_nextState = w_last ? DONE : ADD;
         end
         DONE: begin
            done        = 1'b1;
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Operand latch, nibble walk and result assembly.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_opA <= '0;
         r_opB <= '0;
         r_idx <= '0;
         r_cy  <= 1'b0;
         r_p   <= '0;
         r_sum <= '0;
      end else begin
         if ((r_state == IDLE) && start) begin
            r_opA <= op_a;
            r_opB <= op_b;
            r_idx <= '0;
            r_cy  <= 1'b0;
            r_sum <= '0;
         end
         if ((r_state == ADD) && r_cy) begin
            r_p <= add_c;
         end
         if (w_write) begin
            r_sum[{r_idx, 2'b00} +: 4] <= add_c[3:0];
            r_cy <= w_newCy;
            if (w_last) begin
               r_sum[W] <= w_newCy;
            end else begin
               r_idx <= r_idx + IW'(1);
            end
         end
      end
   end

endmodule
